seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shift engine: the successor to the fixed 32-bit shift/load register.
- Captures an operand and a shift amount, then shifts one bit position per clock in the selected mode.
- Signals completion with a one-cycle done pulse and holds the result until the next accepted start.
- Intended as the shift datapath for sequential ALU, multiplier and divider units.

Parameters:
- WIDTH, 32: operand/result width in bits, minimum 2.
- AMT_W, 5: width of the shift-amount port; must satisfy 2**AMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when accepted (state IDLE or DONE).
- mode  input  3  operation, captured on an accepted start.
- din  input  WIDTH  operand, captured on an accepted start.
- amt  input  AMT_W  shift count, captured on an accepted start.
- shiftin  input  1  fill bit for SLL/SRL, captured on an accepted start.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle completion pulse.
- dout  output  WIDTH  result register.
- carry_out  output  1  last bit shifted out.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset (any time, including mid-shift): state=IDLE, dout=0, carry_out=0, done=0, busy=0, internal count=0.
- States are IDLE, SHIFT and DONE.
  - IDLE: on start=1 at edge E0, dout<=din, cnt<=amt, captured mode/fill registered, carry_out<=0.
    - Next state is SHIFT if amt!=0 and mode is a shift mode; otherwise DONE.
  - SHIFT: each edge shifts dout by one position per mode, carry_out<=the bit leaving the register, cnt<=cnt-1.
    - When cnt==1 the next state is DONE.
  - DONE: done=1 for this cycle only; next state is IDLE.
    - A start in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- Latency: done is high during the cycle following edge E0+amt for amt>=1; for amt=0 or LOAD it follows edge E0. Amounts >= WIDTH are legal and shift the full count.
- start while in SHIFT is ignored; inputs are not re-sampled.
- dout and carry_out hold their values in IDLE and DONE.
- mode encoding:
  - 000 SLL: dout<={dout[WIDTH-2:0],fill}; carry=dout[WIDTH-1].
  - 001 SRL: dout<={fill,dout[WIDTH-1:1]}; carry=dout[0].
  - 010 SRA: dout<={dout[WIDTH-1],dout[WIDTH-1:1]}; carry=dout[0].
  - 011 LOAD: dout<=din; amt ignored; goes straight to DONE.
  - 100 ROL and 101 ROR: see Optional Feature.
  - 110/111: treated as LOAD.
- busy and done are never high together.

Optional Feature:
- Macro SEQ_SHIFT_ROTATE_EN.
- Defined: 100 ROL, dout<={dout[WIDTH-2:0],dout[WIDTH-1]}, carry=dout[WIDTH-1]; 101 ROR, dout<={dout[0],dout[WIDTH-1:1]}, carry=dout[0].
- Not defined: 100/101 behave as LOAD (no shifting, done after E0). No rotate logic is synthesised.

Test Plan:
- SLL: din=0x00000001, amt=4, shiftin=0 → done after E0+4, dout=0x00000010, carry_out=0, busy high for 4 cycles.
- SRA: din=0x80000000, amt=31 → dout=0xFFFFFFFF, carry_out=0; SRL with shiftin=1, din=0x0000000F, amt=2 → dout=0xC0000003, carry_out=1.
- amt=0 (SLL, din=0xA5A5A5A5) and LOAD mode → done one cycle after start, dout=0xA5A5A5A5, busy never high.
- start pulsed with din=0xFFFFFFFF during SHIFT of an SLL of din=0x1 by 8 → ignored, result 0x00000100; a new start in the DONE cycle is accepted and its done follows the first.
- Reset asserted mid-shift (cycle 3 of amt=10) → immediately dout=0, busy=0, done=0; after release a fresh start completes normally.
- With SEQ_SHIFT_ROTATE_EN: ROR din=0x00000001, amt=1 → dout=0x80000000, carry_out=1. Without it: same stimulus → dout=0x00000001, done after E0.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift engine: captures operand and count, shifts one bit per clock, pulses done.
// Optional rotate modes (ROL/ROR) are compiled in when SEQ_SHIFT_ROTATE_EN is defined.
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             shiftin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
`ifdef SEQ_SHIFT_ROTATE_EN
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic             start_is_shift;

  // Every mode not listed here collapses to LOAD and finishes immediately.
  always_comb begin
    case (mode)
      M_SLL, M_SRL, M_SRA: start_is_shift = 1'b1;
`ifdef SEQ_SHIFT_ROTATE_EN
      M_ROL, M_ROR:        start_is_shift = 1'b1;
`endif
      default:             start_is_shift = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          dout_d  = din;
          cnt_d   = amt;
          mode_d  = mode;
          fill_d  = shiftin;
          carry_d = 1'b0;
          state_d = (start_is_shift && (amt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        case (mode_q)
          M_SLL: begin
            dout_d  = {dout_q[WIDTH-2:0], fill_q};
            carry_d = dout_q[WIDTH-1];
          end
          M_SRL: begin
            dout_d  = {fill_q, dout_q[WIDTH-1:1]};
            carry_d = dout_q[0];
          end
          M_SRA: begin
            dout_d  = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
            carry_d = dout_q[0];
          end
`ifdef SEQ_SHIFT_ROTATE_EN
          M_ROL: begin
            dout_d  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            carry_d = dout_q[WIDTH-1];
          end
          M_ROR: begin
            dout_d  = {dout_q[0], dout_q[WIDTH-1:1]};
            carry_d = dout_q[0];
          end
`endif
          default: ;
        endcase
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign dout      = dout_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: driver pushes expected results, monitor checks on done.
// Rotate expectations follow SEQ_SHIFT_ROTATE_EN.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] din = '0;
  logic [4:0]  amt = '0;
  logic        shiftin = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] dout;

  seq_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
    .amt(amt), .shiftin(shiftin), .busy(busy), .done(done), .dout(dout),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        carry;
    int          done_cyc;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation for every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("op %s: dout=0x%08h carry=%0b cycle=%0d busy=%0d", e.name, dout, carry_out, cyc, busy_cnt);
          check({e.name, "_dout"}, dout, e.dout);
          check({e.name, "_carry"}, 32'(carry_out), 32'(e.carry));
          check({e.name, "_latency"}, cyc, e.done_cyc);
          check({e.name, "_busy"}, busy_cnt, e.busy_cycles);
        end
        busy_cnt = 0;
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge E0.
  task automatic issue(input string name, input logic [2:0] m, input logic [31:0] d,
                       input logic [4:0] a, input logic fill, input logic [31:0] exp_dout,
                       input logic exp_carry, input int lat, input int busy_cycles);
    exp_t e;
    mode = m; din = d; amt = a; shiftin = fill; start = 1'b1;
    e.name = name; e.dout = exp_dout; e.carry = exp_carry;
    e.done_cyc = cyc + 1 + lat; e.busy_cycles = busy_cycles;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int e0a;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_dout", dout, 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("sll_1x4", 3'b000, 32'h0000_0001, 5'd4, 1'b0, 32'h0000_0010, 1'b0, 4, 4);
    wait_done();
    issue("sra_31", 3'b010, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 31, 31);
    wait_done();
    issue("srl_fill1", 3'b001, 32'h0000_000F, 5'd2, 1'b1, 32'hC000_0003, 1'b1, 2, 2);
    wait_done();
    issue("load", 3'b011, 32'hA5A5_A5A5, 5'd7, 1'b0, 32'hA5A5_A5A5, 1'b0, 0, 0);
    wait_done();
    issue("sll_amt0", 3'b000, 32'hA5A5_A5A5, 5'd0, 1'b1, 32'hA5A5_A5A5, 1'b0, 0, 0);
    wait_done();
    issue("mode110", 3'b110, 32'h1234_5678, 5'd3, 1'b0, 32'h1234_5678, 1'b0, 0, 0);
    wait_done();
    issue("sll_fill1", 3'b000, 32'h0000_0000, 5'd3, 1'b1, 32'h0000_0007, 1'b0, 3, 3);
    wait_done();
`ifdef SEQ_SHIFT_ROTATE_EN
    issue("ror_1", 3'b101, 32'h0000_0001, 5'd1, 1'b0, 32'h8000_0000, 1'b1, 1, 1);
`else
    issue("ror_as_load", 3'b101, 32'h0000_0001, 5'd1, 1'b0, 32'h0000_0001, 1'b0, 0, 0);
`endif
    wait_done();

    // Start during SHIFT must be ignored; start in the DONE cycle is accepted.
    issue("sll_1x8", 3'b000, 32'h0000_0001, 5'd8, 1'b0, 32'h0000_0100, 1'b0, 8, 8);
    e0a = cyc;
    repeat (2) @(negedge clk);
    mode = 3'b000; din = 32'hFFFF_FFFF; amt = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0a + 8) @(negedge clk);
    check("in_done_cycle", 32'(done), 32'd1);
    issue("b2b_sll", 3'b000, 32'h8000_0001, 5'd1, 1'b0, 32'h0000_0002, 1'b1, 1, 1);
    wait_done();

    // Asynchronous reset in the third shift cycle.
    issue("sll_aborted", 3'b000, 32'h0000_0001, 5'd10, 1'b0, 32'h0, 1'b0, 10, 10);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_dout", dout, 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue("sra_after_reset", 3'b010, 32'hF000_0001, 5'd1, 1'b0, 32'hF800_0000, 1'b1, 1, 1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
